// File: rtl/cosim_commit_pkg.sv
// Record format and constants shared by the co-simulation commit queue and the bench-side checker.
package cosim_commit_pkg;

    localparam int XLEN_W   = 64;
    localparam int HART_W   = 8;
    localparam int SEQ_W    = 32;
    localparam int INS_W    = 32;
    localparam int DST_W    = 5;
    localparam int PRIV_W   = 2;

    localparam logic REC_COMMIT = 1'b0;
    localparam logic REC_IRQ    = 1'b1;

    typedef struct packed {
        logic                kind;
        logic [HART_W-1:0]   hart;
        logic [SEQ_W-1:0]    seq;
        logic [XLEN_W-1:0]   pc;
        logic [INS_W-1:0]    ins;
        logic [DST_W-1:0]    dst;
        logic                wr_valid;
        logic [XLEN_W-1:0]   data;
        logic                xcpt;
        logic [XLEN_W-1:0]   xcpt_cause;
        logic [PRIV_W-1:0]   priv;
    } cosim_rec_t;

endpackage

// File: rtl/cosim_fifo_2w1r.sv
// Generic two-write, one-read synchronous FIFO. Slot 1 is written after slot 0 and
// must only be enabled together with slot 0; the caller guarantees free space.
module cosim_fifo_2w1r #(
    parameter type T     = logic [7:0],
    parameter int  DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr0_en,
    input  T              wr0_data,
    input  logic          wr1_en,
    input  T              wr1_data,
    input  logic          rd_en,
    output T              rd_data,
    output logic [CW-1:0] count
);

    T              mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          pop_s;

    assign pop_s = rd_en && (count_r != {CW{1'b0}});
    assign count = count_r;

    // Storage array; no reset needed because the head output is gated while empty
    always_ff @(posedge clk) begin
        if (wr0_en) begin
            mem_r[wr_ptr_r] <= wr0_data;
        end
        if (wr1_en) begin
            mem_r[wr_ptr_r + AW'(1)] <= wr1_data;
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            wr_ptr_r <= wr_ptr_r + AW'(wr0_en) + AW'(wr1_en);
            rd_ptr_r <= rd_ptr_r + AW'(pop_s);
            count_r  <= count_r + CW'(wr0_en) + CW'(wr1_en) - CW'(pop_s);
        end
    end

    // Head record, forced to zero while empty so reset reads back all-zero
    always_comb begin
        rd_data = '0;
        if (count_r != {CW{1'b0}}) begin
            rd_data = mem_r[rd_ptr_r];
        end else begin
            rd_data = '0;
        end
    end

endmodule

// File: rtl/cosim_commit_queue.sv
// Per-hart producer of retire and external-interrupt records for Spike co-simulation,
// queued in program order with drop accounting when the checker falls behind.
module cosim_commit_queue
    import cosim_commit_pkg::*;
#(
    parameter int HART_ID = 0,
    parameter int DEPTH   = 8,
    parameter int XLEN    = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             commit_valid,
    input  logic [XLEN-1:0]  commit_pc,
    input  logic [31:0]      commit_ins,
    input  logic [4:0]       commit_dst,
    input  logic             commit_wr_valid,
    input  logic [XLEN-1:0]  commit_data,
    input  logic             commit_xcpt,
    input  logic [XLEN-1:0]  commit_xcpt_cause,
    input  logic [1:0]       commit_priv,
    input  logic [XLEN-1:0]  mip_ext,
    output logic             rec_valid,
    input  logic             rec_ready,
    output cosim_rec_t       rec,
    output logic             overflow,
    output logic [15:0]      drop_cnt
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [XLEN-1:0]  mip_q_r;
    logic [SEQ_W-1:0] seq_r;
    logic [15:0]      drop_cnt_r;
    logic             overflow_r;
    logic [CW-1:0]    count_s;
    logic [CW-1:0]    free_s;
    logic             irq_ev_s;
    logic             commit_acc_s;
    logic             irq_acc_s;
    logic [1:0]       drop_inc_s;
    logic [16:0]      drop_sum_s;
    cosim_rec_t       commit_rec_s;
    cosim_rec_t       irq_rec_s;
    cosim_rec_t       wr0_data_s;
    logic             wr0_en_s;
    logic             wr1_en_s;

    assign irq_ev_s = (mip_ext != mip_q_r);
    assign free_s   = CW'(DEPTH) - count_s;

    // Admission: the commit claims space first, the IRQ needs whatever is left after it
    always_comb begin
        commit_acc_s = 1'b0;
        irq_acc_s    = 1'b0;
        if (commit_valid && (free_s >= CW'(1))) begin
            commit_acc_s = 1'b1;
        end else begin
            commit_acc_s = 1'b0;
        end
        if (irq_ev_s && (free_s >= (commit_valid ? CW'(2) : CW'(1)))) begin
            irq_acc_s = 1'b1;
        end else begin
            irq_acc_s = 1'b0;
        end
        drop_inc_s = 2'(commit_valid && !commit_acc_s) + 2'(irq_ev_s && !irq_acc_s);
        drop_sum_s = {1'b0, drop_cnt_r} + 17'(drop_inc_s);
    end

    // Record assembly and placement of accepted events into the FIFO write slots
    always_comb begin
        commit_rec_s            = '0;
        commit_rec_s.kind       = REC_COMMIT;
        commit_rec_s.hart       = HART_W'(HART_ID);
        commit_rec_s.seq        = seq_r;
        commit_rec_s.pc         = XLEN_W'(commit_pc);
        commit_rec_s.ins        = commit_ins;
        commit_rec_s.dst        = commit_dst;
        commit_rec_s.wr_valid   = commit_wr_valid;
        commit_rec_s.data       = XLEN_W'(commit_data);
        commit_rec_s.xcpt       = commit_xcpt;
        commit_rec_s.xcpt_cause = XLEN_W'(commit_xcpt_cause);
        commit_rec_s.priv       = commit_priv;

        irq_rec_s      = '0;
        irq_rec_s.kind = REC_IRQ;
        irq_rec_s.hart = HART_W'(HART_ID);
        irq_rec_s.seq  = seq_r + SEQ_W'(commit_acc_s);
        irq_rec_s.data = XLEN_W'(mip_ext);

        if (commit_acc_s) begin
            wr0_data_s = commit_rec_s;
        end else begin
            wr0_data_s = irq_rec_s;
        end
        wr0_en_s = commit_acc_s || irq_acc_s;
        wr1_en_s = commit_acc_s && irq_acc_s;
    end

    // Interrupt history, sequence numbering and drop accounting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mip_q_r    <= {XLEN{1'b0}};
            seq_r      <= {SEQ_W{1'b0}};
            drop_cnt_r <= 16'h0000;
            overflow_r <= 1'b0;
        end else begin
            mip_q_r <= mip_ext;
            seq_r   <= seq_r + SEQ_W'(commit_acc_s) + SEQ_W'(irq_acc_s);
            if (drop_inc_s != 2'd0) begin
                overflow_r <= 1'b1;
                drop_cnt_r <= (drop_sum_s > 17'h0FFFF) ? 16'hFFFF : drop_sum_s[15:0];
            end
        end
    end

    cosim_fifo_2w1r #(
        .T     (cosim_rec_t),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr0_en   (wr0_en_s),
        .wr0_data (wr0_data_s),
        .wr1_en   (wr1_en_s),
        .wr1_data (irq_rec_s),
        .rd_en    (rec_ready),
        .rd_data  (rec),
        .count    (count_s)
    );

    assign rec_valid = (count_s != {CW{1'b0}});
    assign overflow  = overflow_r;
    assign drop_cnt  = drop_cnt_r;

endmodule

// File: tb/tb_cosim_commit_queue.sv
// Directed bench for cosim_commit_queue: ordering, capacity/drop rules, reset behaviour.
module tb_cosim_commit_queue;
    import cosim_commit_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        commit_valid = 1'b0;
    logic [63:0] commit_pc = 64'd0;
    logic [31:0] commit_ins = 32'd0;
    logic [4:0]  commit_dst = 5'd0;
    logic        commit_wr_valid = 1'b0;
    logic [63:0] commit_data = 64'd0;
    logic        commit_xcpt = 1'b0;
    logic [63:0] commit_xcpt_cause = 64'd0;
    logic [1:0]  commit_priv = 2'd0;
    logic [63:0] mip_ext = 64'd0;
    logic        rec_valid;
    logic        rec_ready = 1'b0;
    cosim_rec_t  rec;
    logic        overflow;
    logic [15:0] drop_cnt;

    int vectors = 0;
    int miscompares = 0;

    cosim_commit_queue #(.HART_ID(0), .DEPTH(8), .XLEN(64)) dut (
        .clk(clk), .rst_n(rst_n), .commit_valid(commit_valid), .commit_pc(commit_pc),
        .commit_ins(commit_ins), .commit_dst(commit_dst), .commit_wr_valid(commit_wr_valid),
        .commit_data(commit_data), .commit_xcpt(commit_xcpt),
        .commit_xcpt_cause(commit_xcpt_cause), .commit_priv(commit_priv), .mip_ext(mip_ext),
        .rec_valid(rec_valid), .rec_ready(rec_ready), .rec(rec), .overflow(overflow),
        .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        commit_valid = 1'b0;
        mip_ext      = 64'd0;
        rec_ready    = 1'b0;
        rst_n        = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic push_commits(input int n);
        for (int i = 0; i < n; i++) begin
            commit_valid = 1'b1;
            commit_pc    = 64'h1000 + 64'(i * 4);
            step();
        end
        commit_valid = 1'b0;
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("rst_valid", 64'(rec_valid), 64'd0);
        chk("rst_rec_zero", 64'(rec === '0), 64'd1);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);

        // Single commit with ready held high
        rec_ready       = 1'b1;
        commit_valid    = 1'b1;
        commit_pc       = 64'h8000_0000;
        commit_ins      = 32'h0050_0293;
        commit_dst      = 5'd5;
        commit_wr_valid = 1'b1;
        commit_data     = 64'h1234;
        commit_priv     = 2'd3;
        step();
        commit_valid = 1'b0;
        chk("t1_valid", 64'(rec_valid), 64'd1);
        chk("t1_kind", 64'(rec.kind), 64'd0);
        chk("t1_seq", 64'(rec.seq), 64'd0);
        chk("t1_pc", rec.pc, 64'h8000_0000);
        chk("t1_ins", 64'(rec.ins), 64'h0050_0293);
        chk("t1_dst", 64'(rec.dst), 64'd5);
        chk("t1_wr_valid", 64'(rec.wr_valid), 64'd1);
        chk("t1_data", rec.data, 64'h1234);
        chk("t1_priv", 64'(rec.priv), 64'd3);
        step();
        chk("t1_valid_after", 64'(rec_valid), 64'd0);

        // Commit and interrupt change together: commit first, then IRQ
        do_reset();
        commit_valid = 1'b1;
        commit_pc    = 64'h8000_0004;
        mip_ext      = 64'h800;
        step();
        commit_valid = 1'b0;
        chk("t2_valid", 64'(rec_valid), 64'd1);
        chk("t2_first_kind", 64'(rec.kind), 64'd0);
        chk("t2_first_seq", 64'(rec.seq), 64'd0);
        rec_ready = 1'b1;
        step();
        chk("t2_second_kind", 64'(rec.kind), 64'd1);
        chk("t2_second_seq", 64'(rec.seq), 64'd1);
        chk("t2_second_data", rec.data, 64'h800);
        chk("t2_second_pc", rec.pc, 64'd0);
        chk("t2_second_dst", 64'(rec.dst), 64'd0);
        step();
        chk("t2_empty", 64'(rec_valid), 64'd0);

        // Nine commits into an 8-deep queue with ready low
        do_reset();
        push_commits(9);
        chk("t3_overflow", 64'(overflow), 64'd1);
        chk("t3_drop_cnt", 64'(drop_cnt), 64'd1);
        rec_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("t3_drain_valid", 64'(rec_valid), 64'd1);
            chk("t3_drain_seq", 64'(rec.seq), 64'(i));
            chk("t3_drain_pc", rec.pc, 64'h1000 + 64'(i * 4));
            step();
        end
        chk("t3_empty", 64'(rec_valid), 64'd0);
        chk("t3_drop_sticky", 64'(drop_cnt), 64'd1);

        // Free=1 with commit and IRQ together: IRQ dropped and never re-reported
        do_reset();
        push_commits(7);
        commit_valid = 1'b1;
        commit_pc    = 64'h2000;
        mip_ext      = 64'h800;
        step();
        commit_valid = 1'b0;
        chk("t4_drop_cnt", 64'(drop_cnt), 64'd1);
        chk("t4_overflow", 64'(overflow), 64'd1);
        step();
        step();
        chk("t4_no_rereport", 64'(drop_cnt), 64'd1);
        rec_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("t4_drain_kind", 64'(rec.kind), 64'd0);
            chk("t4_drain_seq", 64'(rec.seq), 64'(i));
            step();
        end
        chk("t4_last_empty", 64'(rec_valid), 64'd0);
        step();
        chk("t4_no_irq", 64'(rec_valid), 64'd0);

        // Full queue with simultaneous pop and push: push dropped, 7 remain
        do_reset();
        push_commits(8);
        rec_ready    = 1'b1;
        commit_valid = 1'b1;
        commit_pc    = 64'h3000;
        step();
        commit_valid = 1'b0;
        rec_ready    = 1'b0;
        chk("t5_drop_cnt", 64'(drop_cnt), 64'd1);
        chk("t5_head_seq", 64'(rec.seq), 64'd1);
        rec_ready = 1'b1;
        for (int i = 1; i < 8; i++) begin
            chk("t5_drain_seq", 64'(rec.seq), 64'(i));
            step();
        end
        chk("t5_empty_after_7", 64'(rec_valid), 64'd0);

        // Asynchronous reset with 5 records queued
        do_reset();
        push_commits(5);
        chk("t6_pre_valid", 64'(rec_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_valid", 64'(rec_valid), 64'd0);
        chk("t6_async_rec_zero", 64'(rec === '0), 64'd1);
        chk("t6_async_drop", 64'(drop_cnt), 64'd0);
        mip_ext      = 64'h800;
        commit_valid = 1'b1;
        step();
        step();
        chk("t6_ignored_in_reset", 64'(rec_valid), 64'd0);
        commit_valid = 1'b0;
        rst_n = 1'b1;
        step();
        chk("t6_irq_valid", 64'(rec_valid), 64'd1);
        chk("t6_irq_kind", 64'(rec.kind), 64'd1);
        chk("t6_irq_seq", 64'(rec.seq), 64'd0);
        chk("t6_irq_data", rec.data, 64'h800);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cosim_commit_queue.md
# cosim_commit_queue

RTL-side producer for Spike co-simulation. It captures per-hart retire events and external-interrupt (mip) changes from the core and queues them in program order. It presents them one at a time on a valid/ready port, where the bench checker pops each record and replays it against Spike's step and commit results or its interrupt setter. One instance sits per hart, under the MEEP_COSIM build only.

## Interface
- HART_ID, 0: hart index stamped into every record.
- DEPTH, 8: queue entries, power of two, ≥4.
- XLEN, 64: width of PC, data and cause fields.
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- commit_valid  in  1  one instruction retires this cycle.
- commit_pc  in  XLEN  retired PC.
- commit_ins  in  32  instruction bits.
- commit_dst  in  5  destination register.
- commit_wr_valid  in  1  register write occurred.
- commit_data  in  XLEN  write-back value.
- commit_xcpt  in  1  instruction trapped.
- commit_xcpt_cause  in  XLEN  trap cause.
- commit_priv  in  2  privilege level after retire.
- mip_ext  in  XLEN  current external-interrupt pending vector.
- rec_valid  out  1  head record available.
- rec_ready  in  1  checker consumes head.
- rec  out  cosim_rec_t  head record: kind, hart, seq, and payload fields above.
- overflow  out  1  sticky; set when any event was dropped.
- drop_cnt  out  16  saturating count of dropped events.

## Operation
- Event sources per cycle:
  - Commit event when commit_valid=1.
  - Interrupt event when mip_ext differs from its registered previous value, mip_q.
- Both events in the same cycle produce two pushes: the commit goes first, then the interrupt.
- Record kind: 0 = COMMIT, 1 = IRQ.
  - An IRQ record carries the new mip_ext in its data field; its other payload fields are 0.
- seq is a 32-bit counter. It increments once per accepted record, wraps from 2^32-1 to 0, and drops do not consume a seq value.
- Capacity check uses the registered count only; a pop in the same cycle does not free space.
  - Free ≥ 2: all events are accepted.
  - Free = 1: the commit is accepted; a same-cycle IRQ is dropped.
  - Free = 0: all events are dropped.
- Each dropped event increments drop_cnt, which saturates at 0xFFFF, and sets overflow.
- mip_q updates every cycle, even when its IRQ event is dropped. A dropped IRQ is therefore never re-reported.
- Pop occurs when rec_valid && rec_ready.
- rec must stay stable while rec_valid=1 and rec_ready=0.
- Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is log2(DEPTH)+1 bits.

## Timing
- A record pushed in cycle N is visible at the head in cycle N+1 at the earliest. There is no empty-queue bypass.
- Throughput: 2 pushes and 1 pop per cycle.
- rec_valid equals (count != 0), driven from registers.
- Reset, asynchronous on rst_n low:
  - count, pointers, seq, drop_cnt = 0.
  - overflow = 0; rec_valid = 0; rec reads as all-zero.
  - mip_q = 0.
- Reset asserted mid-operation discards all queued records immediately.
- Events are ignored while rst_n=0. In the first cycle after release, a nonzero mip_ext produces an IRQ record.
- overflow and drop_cnt clear only on reset.

## Structure
- cosim_commit_pkg holds:
  - typedef cosim_rec_t (packed struct: kind, hart, seq, pc, ins, dst, wr_valid, data, xcpt, xcpt_cause, priv).
  - REC_COMMIT and REC_IRQ constants.
  - Field-width localparams matching the bench-side core_commit_info_t.
- Sub-module cosim_fifo_2w1r: a generic 2-write, 1-read synchronous FIFO with count output, parameterised by data type and DEPTH.
- The top level contains the event detection, capacity/drop logic and counters.

## Test plan
- Single commit, pc=0x8000_0000, wr_valid=1, dst=5, data=0x1234, with rec_ready held 1 → rec_valid high exactly the next cycle with kind=0, seq=0 and matching fields, then rec_valid low.
- Commit and mip_ext change 0→0x800 in the same cycle → two records in the order COMMIT (seq 0), IRQ (seq 1, data=0x800).
- rec_ready=0, DEPTH=8, 9 consecutive commits → 8 accepted with seq 0..7; the 9th is dropped, drop_cnt=1, overflow=1; records drain in order once ready rises.
- Count=7 (free=1), commit and IRQ in the same cycle → commit accepted, IRQ dropped, drop_cnt increments by 1, and a later unchanged mip_ext produces no IRQ.
- Full queue with simultaneous pop and push → the push is dropped (no same-cycle free); count becomes 7.
- Reset asserted with 5 records queued → rec_valid=0 and counters zero asynchronously; after release with mip_ext=0x800 → an IRQ record with seq=0.
